// File: rtl/id_stall_stage_pkg.sv
// ============================================================================
// id_stall_stage_pkg : shared encodings for the IF/ID + ID/EX stall stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package id_stall_stage_pkg;

    localparam int          REG_ADDR_SIZE = 4;
    localparam logic [31:0] NOP           = 32'h0000_0013;
    localparam logic [6:0]  OPC_STORE     = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH    = 7'b1100011;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/id_stall_stage_rd_extract.sv
// ============================================================================
// rd_extract : destination register of the ID instruction, zeroed when the
// slot is empty or the opcode never writes back. Revision: 1.0
// ============================================================================
`default_nettype none

module rd_extract
    import id_stall_stage_pkg::*;
(
    input  logic                     valid,
    input  logic [11:0]              instr_lo,
    output logic [REG_ADDR_SIZE:0]   rd
);

    logic [6:0] opcode;
    logic       no_wb;

    assign opcode = instr_lo[6:0];
    assign no_wb  = (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    assign rd     = (valid && !no_wb) ? instr_lo[11:7] : '0;

endmodule

`default_nettype wire

// File: rtl/id_stall_stage.sv
// ============================================================================
// id_stall_stage : IF/ID and ID/EX registers with stall hold, bubble
// injection, branch squash and a saturating stall-cycle counter. Revision: 1.0
// ============================================================================
`default_nettype none

module id_stall_stage
    import id_stall_stage_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [31:0]              if_pc,
    input  logic [31:0]              if_instr,
    output logic                     if_ready,
    output logic                     id_valid,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_instr,
    output logic [REG_ADDR_SIZE:0]   id_rs1,
    output logic [REG_ADDR_SIZE:0]   id_rs2,
    output logic                     exe_valid,
    output logic [31:0]              exe_pc,
    output logic [31:0]              exe_instr,
    output logic [REG_ADDR_SIZE:0]   exe_rd,
    output logic [CNT_WIDTH-1:0]     stall_cnt
);

    state_t                  st;
    logic                    hold;
    logic [REG_ADDR_SIZE:0]  id_rd;
    logic                    st_unused;

    // A stall against an empty ID slot is a false hazard and is ignored.
    assign hold     = stall & id_valid & ~flush;
    assign if_ready = flush | ~(stall & id_valid);

    assign id_rs1   = id_valid ? id_instr[19:15] : '0;
    assign id_rs2   = id_valid ? id_instr[24:20] : '0;

    // State is kept for observability in debug; no datapath decision reads it.
    assign st_unused = ^st;

    rd_extract u_rd_extract (
        .valid    (id_valid),
        .instr_lo (id_instr[11:0]),
        .rd       (id_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= RUN;
            id_valid  <= 1'b0;
            id_pc     <= '0;
            id_instr  <= NOP;
            exe_valid <= 1'b0;
            exe_pc    <= '0;
            exe_instr <= NOP;
            exe_rd    <= '0;
            stall_cnt <= '0;
        end else if (flush) begin
            st        <= SQUASH;
            id_valid  <= 1'b0;
            id_instr  <= NOP;
            exe_valid <= 1'b0;
            exe_instr <= NOP;
            exe_rd    <= '0;
        end else if (hold) begin
            st        <= HOLD;
            exe_valid <= 1'b0;
            exe_instr <= NOP;
            exe_rd    <= '0;
            if (stall_cnt != {CNT_WIDTH{1'b1}}) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end else begin
            st        <= RUN;
            id_valid  <= if_valid;
            id_pc     <= if_pc;
            id_instr  <= if_instr;
            exe_valid <= id_valid;
            exe_pc    <= id_pc;
            exe_instr <= id_instr;
            exe_rd    <= id_rd;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_stall_stage.sv
// ============================================================================
// tb_id_stall_stage : directed stimulus, scoreboard of instructions expected
// to reach EXE, monitor pops on every live EXE cycle. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_stall_stage;

    localparam logic [31:0] NOP_I = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, flush, if_valid;
    logic [31:0] if_pc, if_instr;
    logic        if_ready, id_valid, exe_valid;
    logic [31:0] id_pc, id_instr, exe_pc, exe_instr;
    logic [4:0]  id_rs1, id_rs2, exe_rd;
    logic [3:0]  stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    id_stall_stage #(.CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_ready(if_ready), .id_valid(id_valid), .id_pc(id_pc),
        .id_instr(id_instr), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_instr(exe_instr),
        .exe_rd(exe_rd), .stall_cnt(stall_cnt)
    );

    function automatic logic [31:0] mk(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [4:0] rd, input logic [6:0] op);
        return {7'd0, rs2, rs1, 3'd0, rd, op};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd);
        exp_t e;
        e.pc = pc; e.instr = instr; e.rd = rd;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        if_valid = v; if_pc = pc; if_instr = instr;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        fetch(1'b0, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    // Monitor: every live EXE cycle must match the oldest expected instruction.
    always @(negedge clk) begin
        if (!reset && exe_valid) begin
            if (q.size() == 0) begin
                check("unexpected_exe", {32'h0, exe_pc}, 64'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_exe_pc", {32'h0, exe_pc}, {32'h0, e.pc});
                check("sb_exe_instr", {32'h0, exe_instr}, {32'h0, e.instr});
                check("sb_exe_rd", {59'h0, exe_rd}, {59'h0, e.rd});
            end
        end
    end

    logic [31:0] i0, i1, i2, w, x5, y, a, b, c, d, e4, f4, g4, sw, br, h, j;

    initial begin
        i0 = mk(5'd2, 5'd1, 5'd3, 7'b0010011);
        i1 = mk(5'd4, 5'd6, 5'd8, 7'b0110011);
        i2 = mk(5'd0, 5'd9, 5'd10, 7'b0000011);
        w  = mk(5'd0, 5'd1, 5'd11, 7'b0010011);
        x5 = mk(5'd0, 5'd0, 5'd5, 7'b0010011);
        y  = mk(5'd5, 5'd5, 5'd12, 7'b0110011);
        a  = mk(5'd0, 5'd2, 5'd13, 7'b0010011);
        b  = mk(5'd0, 5'd3, 5'd14, 7'b0010011);
        c  = mk(5'd0, 5'd4, 5'd15, 7'b0010011);
        d  = mk(5'd0, 5'd5, 5'd16, 7'b0010011);
        e4 = mk(5'd0, 5'd6, 5'd17, 7'b0010011);
        f4 = mk(5'd0, 5'd7, 5'd18, 7'b0010011);
        g4 = mk(5'd0, 5'd8, 5'd19, 7'b0010011);
        sw = mk(5'd3, 5'd2, 5'd7, 7'b0100011);
        br = mk(5'd1, 5'd2, 5'd3, 7'b1100011);
        h  = mk(5'd0, 5'd1, 5'd20, 7'b0010011);
        j  = mk(5'd0, 5'd1, 5'd21, 7'b0010011);

        // Reset state
        do_reset();
        check("rst_id_valid", {63'h0, id_valid}, 64'h0);
        check("rst_exe_valid", {63'h0, exe_valid}, 64'h0);
        check("rst_id_pc", {32'h0, id_pc}, 64'h0);
        check("rst_exe_pc", {32'h0, exe_pc}, 64'h0);
        check("rst_id_instr", {32'h0, id_instr}, {32'h0, NOP_I});
        check("rst_exe_instr", {32'h0, exe_instr}, {32'h0, NOP_I});
        check("rst_exe_rd", {59'h0, exe_rd}, 64'h0);
        check("rst_cnt", {60'h0, stall_cnt}, 64'h0);
        check("rst_if_ready", {63'h0, if_ready}, 64'h1);

        // Straight flow: two-cycle latency to EXE
        push(32'h0, i0, 5'd3); push(32'h4, i1, 5'd8); push(32'h8, i2, 5'd10);
        fetch(1'b1, 32'h0, i0); tick();
        check("flow_id_pc", {32'h0, id_pc}, 64'h0);
        check("flow_id_rs1", {59'h0, id_rs1}, 64'd1);
        check("flow_id_rs2", {59'h0, id_rs2}, 64'd2);
        fetch(1'b1, 32'h4, i1); tick();
        check("flow_lat_exe_pc", {32'h0, exe_pc}, 64'h0);
        check("flow_lat_exe_valid", {63'h0, exe_valid}, 64'h1);
        fetch(1'b1, 32'h8, i2); tick();
        fetch(1'b0, 32'h0, 32'h0); tick();
        check("flow_id_rs1_empty", {59'h0, id_rs1}, 64'h0);
        tick(); tick();

        // Two-cycle stall with addi x5 in ID
        do_reset();
        push(32'h0c, w, 5'd11); push(32'h10, x5, 5'd5); push(32'h14, y, 5'd12);
        fetch(1'b1, 32'h0c, w); tick();
        fetch(1'b1, 32'h10, x5); tick();
        fetch(1'b1, 32'h14, y); stall = 1'b1; #1;
        check("stall_if_ready0", {63'h0, if_ready}, 64'h0);
        tick();
        check("stall_bubble1_valid", {63'h0, exe_valid}, 64'h0);
        check("stall_bubble1_instr", {32'h0, exe_instr}, {32'h0, NOP_I});
        check("stall_id_hold", {32'h0, id_pc}, 64'h10);
        check("stall_if_ready1", {63'h0, if_ready}, 64'h0);
        tick();
        check("stall_bubble2_rd", {59'h0, exe_rd}, 64'h0);
        check("stall_bubble2_valid", {63'h0, exe_valid}, 64'h0);
        check("stall_cnt2", {60'h0, stall_cnt}, 64'd2);
        stall = 1'b0; #1;
        check("stall_release_ready", {63'h0, if_ready}, 64'h1);
        tick();
        check("stall_held_to_exe", {32'h0, exe_pc}, 64'h10);
        check("stall_cnt_kept", {60'h0, stall_cnt}, 64'd2);
        fetch(1'b0, 32'h0, 32'h0); tick(); tick(); tick();

        // Flush with live IF/ID and ID/EX
        do_reset();
        push(32'h20, a, 5'd13); push(32'h2c, d, 5'd16);
        fetch(1'b1, 32'h20, a); tick();
        fetch(1'b1, 32'h24, b); tick();
        fetch(1'b1, 32'h28, c); flush = 1'b1; #1;
        check("flush_if_ready", {63'h0, if_ready}, 64'h1);
        tick();
        check("flush_id_valid", {63'h0, id_valid}, 64'h0);
        check("flush_id_instr", {32'h0, id_instr}, {32'h0, NOP_I});
        check("flush_exe_valid", {63'h0, exe_valid}, 64'h0);
        check("flush_exe_instr", {32'h0, exe_instr}, {32'h0, NOP_I});
        check("flush_exe_pc_kept", {32'h0, exe_pc}, 64'h20);
        flush = 1'b0; fetch(1'b1, 32'h2c, d); tick();
        check("squash_refill_id", {32'h0, id_pc}, 64'h2c);
        check("squash_exe_bubble", {63'h0, exe_valid}, 64'h0);
        fetch(1'b0, 32'h0, 32'h0); tick(); tick();

        // Stall and flush together, then stall against empty ID
        do_reset();
        push(32'h38, g4, 5'd19);
        fetch(1'b1, 32'h30, e4); tick();
        fetch(1'b1, 32'h34, f4); stall = 1'b1; flush = 1'b1; tick();
        check("sf_id_valid", {63'h0, id_valid}, 64'h0);
        check("sf_exe_valid", {63'h0, exe_valid}, 64'h0);
        check("sf_cnt", {60'h0, stall_cnt}, 64'h0);
        flush = 1'b0; fetch(1'b1, 32'h38, g4); #1;
        check("empty_stall_ready", {63'h0, if_ready}, 64'h1);
        tick();
        check("empty_stall_load", {32'h0, id_pc}, 64'h38);
        check("empty_stall_cnt", {60'h0, stall_cnt}, 64'h0);
        stall = 1'b0; fetch(1'b0, 32'h0, 32'h0); tick(); tick();

        // Store and branch never report a destination
        do_reset();
        push(32'h40, sw, 5'd0); push(32'h44, br, 5'd0);
        fetch(1'b1, 32'h40, sw); tick();
        fetch(1'b1, 32'h44, br); tick();
        check("store_exe_rd", {59'h0, exe_rd}, 64'h0);
        fetch(1'b0, 32'h0, 32'h0); tick(); tick();

        // Counter saturation on a 20-cycle stall
        do_reset();
        push(32'h50, h, 5'd20);
        fetch(1'b1, 32'h50, h); tick();
        fetch(1'b0, 32'h0, 32'h0); stall = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 15) check("sat_cnt15", {60'h0, stall_cnt}, 64'd15);
        end
        check("sat_cnt20", {60'h0, stall_cnt}, 64'd15);
        check("sat_bubble", {63'h0, exe_valid}, 64'h0);
        stall = 1'b0; tick();
        check("sat_release", {32'h0, exe_pc}, 64'h50);
        tick(); tick();

        // Reset during HOLD discards the held instruction
        do_reset();
        fetch(1'b1, 32'h60, j); tick();
        fetch(1'b0, 32'h0, 32'h0); stall = 1'b1;
        tick(); tick(); tick();
        check("hold_cnt3", {60'h0, stall_cnt}, 64'd3);
        check("hold_id_valid", {63'h0, id_valid}, 64'h1);
        reset = 1'b1; stall = 1'b0; tick();
        check("mid_rst_id_valid", {63'h0, id_valid}, 64'h0);
        check("mid_rst_id_pc", {32'h0, id_pc}, 64'h0);
        check("mid_rst_id_instr", {32'h0, id_instr}, {32'h0, NOP_I});
        check("mid_rst_exe_pc", {32'h0, exe_pc}, 64'h0);
        check("mid_rst_cnt", {60'h0, stall_cnt}, 64'h0);
        check("mid_rst_if_ready", {63'h0, if_ready}, 64'h1);
        reset = 1'b0; tick();
        check("mid_rst_after_id", {63'h0, id_valid}, 64'h0);
        check("mid_rst_after_exe", {63'h0, exe_valid}, 64'h0);
        tick();

        check("sb_drained", 64'(q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_stall_stage.md
# id_stall_stage

IF/ID and ID/EX pipeline register pair that consumes the hazard unit's `stall` and the execute stage's `flush`. It holds the fetched instruction in decode while a RAW hazard is pending, injects NOP bubbles into execute, and squashes both stages on a taken branch. It produces the `rd_EXE` value the hazard unit compares against. It also throttles fetch through a ready signal and counts stall cycles for performance monitoring.

## Interface
Parameters:
- `CNT_WIDTH`, 16: stall-cycle counter width.

Ports:
- `clk`  input  1: the single clock for the block; all state updates on its rising edge.
- `reset`  input  1: synchronous, active-high reset, sampled on rising `clk`.
- `stall`  input  1: RAW hazard pending for the instruction in ID (hazard unit output).
- `flush`  input  1: taken branch/jump resolved in EXE; squash IF/ID and ID/EX.
- `if_valid`  input  1: fetch presents a valid instruction.
- `if_pc`  input  32: PC of the fetched instruction.
- `if_instr`  input  32: fetched instruction word.
- `if_ready`  output  1: decode accepts the fetch word this cycle.
- `id_valid`  output  1: ID stage holds a live instruction.
- `id_pc`  output  32: PC of the instruction in ID.
- `id_instr`  output  32: instruction in ID.
- `id_rs1`, `id_rs2`  output  `REG_ADDR_SIZE`+1: `id_instr[19:15]`, `id_instr[24:20]`; forced to 0 when `id_valid`=0.
- `exe_valid`  output  1: EXE stage holds a live instruction.
- `exe_pc`  output  32: PC in EXE.
- `exe_instr`  output  32: instruction in EXE (NOP on bubble).
- `exe_rd`  output  `REG_ADDR_SIZE`+1: destination register in EXE; 0 on bubble or no-writeback opcode.
- `stall_cnt`  output  `CNT_WIDTH`: saturating count of cycles in HOLD.

## Operation
- NOP is 32'h0000_0013 (addi x0,x0,0).
- State machine, state register `st`:
  - RUN: normal advance.
  - HOLD: stalled.
  - SQUASH: one refill cycle after a flush.
- Transitions, evaluated each rising edge, flush has priority:
  - `flush`=1 → SQUASH.
  - else `stall`=1 and `id_valid`=1 → HOLD.
  - else → RUN.
  - SQUASH always exits next cycle by the same rule.
- Register updates per edge:
  - When `flush`=1:
    - `id_valid`←0 and `id_instr`←NOP.
    - ID/EX gets a bubble.
  - When `stall`=1, `id_valid`=1 and `flush`=0:
    - IF/ID holds every field.
    - ID/EX gets a bubble.
  - Otherwise:
    - IF/ID ← (`if_valid`, `if_pc`, `if_instr`).
    - ID/EX ← IF/ID contents.
- Bubble means `exe_valid`=0, `exe_instr`=NOP, `exe_rd`=0, and `exe_pc` unchanged.
- `exe_rd` is captured from `id_instr[11:7]`. It is forced to 0 when `id_valid`=0 or when opcode `id_instr[6:0]` is 7'b0100011 (store) or 7'b1100011 (branch).
- `stall` with `id_valid`=0 is ignored: a stall against an empty ID is a false hazard from zeroed fields.
- `if_ready` = `flush` | ~(`stall` & `id_valid`), combinational. With `flush`=1 the fetch word is discarded regardless of `if_ready`.
- `stall_cnt`:
  - Increments once per edge while the next state is HOLD.
  - Saturates at all-ones and does not wrap.
  - Cleared only by `reset`.
- Downstream requirement: the hazard unit must qualify matches with rd≠0; bubbles drive `exe_rd`=0 for this reason.

## Timing
- Reset values:
  - `st`=RUN.
  - `id_valid`=0, `exe_valid`=0.
  - `id_pc`=0, `exe_pc`=0.
  - `id_instr`=NOP, `exe_instr`=NOP.
  - `exe_rd`=0, `stall_cnt`=0.
  - With `flush`=0, `stall`=0, `if_ready`=1 in the cycle `reset` is high.
- Reset has priority over `flush` and `stall`. Reset mid-HOLD discards the held instruction.
- Latency: fetch word appears on `id_*` 1 cycle after acceptance and on `exe_*` 2 cycles after, absent stalls.
- An N-cycle stall produces exactly N consecutive bubbles in EXE. The held instruction enters EXE on the first edge with `stall`=0.
- Simultaneous `stall`=1 and `flush`=1: the flush wins, no HOLD entry, and `stall_cnt` is not incremented.
- `if_valid`=0 in RUN loads `id_valid`=0 (natural bubble). This does not count as a stall.

## Structure
- NOP encoding, opcode constants (store, branch) and `REG_ADDR_SIZE` go in the shared `def_params.v`. The state encodings go there too: RUN=2'd0, HOLD=2'd1, SQUASH=2'd2.
- One natural sub-module, `rd_extract`: combinational opcode check producing the rd/valid-qualified destination register. The FSM, both register stages and the counter stay in `id_stall_stage`.

## Test plan
- Straight flow: 3 valid instructions, PCs 0x0/0x4/0x8, no stall → each appears on `exe_*` two cycles after its fetch cycle; `exe_rd`=`instr[11:7]`.
- 2-cycle stall with `addi x5` in ID → `if_ready`=0 for 2 cycles, ID holds, exactly 2 bubbles with `exe_rd`=0, then `addi x5` in EXE; `stall_cnt`=2.
- Flush with live instructions in IF/ID and ID/EX → next edge `id_valid`=0 and `exe_valid`=0, `exe_instr`=NOP; state SQUASH for 1 cycle, then RUN.
- `stall`=1 and `flush`=1 in the same cycle → flush behaviour only; `stall_cnt` unchanged. `stall`=1 with `id_valid`=0 → no hold, `if_ready`=1.
- Store `sw` (opcode 0100011) with bits[11:7]=5'd7 → `exe_rd`=0. Counter forced near max (`CNT_WIDTH`=4, 20-cycle stall) → `stall_cnt` saturates at 15.
- `reset` asserted during a HOLD → next edge all outputs at reset values, state RUN, `stall_cnt`=0.
